// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 64'h8000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // one cycle after reset release
        ST_REQ  = 2'd1,   // memory request outstanding, data will be kept
        ST_FULL = 2'd2,   // buffer full, no request issued
        ST_DROP = 2'd3    // request outstanding, data will be discarded
    } fetch_state_e;

    // One buffered instruction together with the address it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned: the two low bits of a target are dropped
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Memory-port and decode-side signals of the fetch unit, grouped in one bundle.
interface ifu_fetch_if;
    import ifu_fetch_pkg::*;

    logic            o_instr_cen;
    logic [XLEN-1:0] o_instr_addr;
    logic [ILEN-1:0] i_instr;
    logic            i_instr_valid;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_if_valid;
    logic [ILEN-1:0] o_if_instr;
    logic [XLEN-1:0] o_if_pc;
    logic            i_id_ready;

    // The fetch unit itself
    modport master (
        output o_instr_cen, o_instr_addr, o_if_valid, o_if_instr, o_if_pc,
        input  i_instr, i_instr_valid, i_redirect, i_redirect_pc, i_id_ready
    );

    // Memory, execute and decode as seen from the fetch unit
    modport slave (
        input  o_instr_cen, o_instr_addr, o_if_valid, o_if_instr, o_if_pc,
        output i_instr, i_instr_valid, i_redirect, i_redirect_pc, i_id_ready
    );

endinterface

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with show-ahead head output and a flush.
// Flush wins over push and pop in the same cycle.
module ifu_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; a push into a full FIFO is accepted only with a pop
    always_comb begin
        do_pop   = pop && !flush && !empty;
        do_push  = push && !flush && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: owns the fetch PC, issues one memory request at a
// time, buffers responses for decode and handles redirects with a flush.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [ILEN-1:0] NOP_INSTR  = NOP_INSTR_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    ifu_fetch_if.master bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;

    logic            instr_cen;
    logic            fifo_push, fifo_pop, fifo_flush;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count, count_after;
    fetch_entry_t    push_entry, fifo_head;
    logic [XLEN-1:0] target_pc;

    assign target_pc  = align_pc(bus.i_redirect_pc);
    assign push_entry = '{pc: fetch_pc_q, instr: bus.i_instr};

    // Next-state, fetch PC and buffer control
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        instr_cen   = 1'b0;
        fifo_push   = 1'b0;
        fifo_flush  = bus.i_redirect;
        fifo_pop    = !fifo_empty && bus.i_id_ready && !bus.i_redirect;
        count_after = fifo_count + CW'(1) - CW'(fifo_pop);

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (bus.i_redirect) fetch_pc_d = target_pc;
            end
            ST_REQ: begin
                instr_cen = 1'b1;
                if (bus.i_redirect) begin
                    fetch_pc_d = target_pc;
                    if (!bus.i_instr_valid) begin
                        // Request cannot be withdrawn: remember it and wait out its data
                        state_d     = ST_DROP;
                        drop_addr_d = fetch_pc_q;
                    end
                end else if (bus.i_instr_valid) begin
                    fifo_push  = 1'b1;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    if (count_after == DEPTH_CNT) state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.i_redirect) begin
                    fetch_pc_d = target_pc;
                    state_d    = ST_REQ;
                end else if (!fifo_full) begin
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                instr_cen = 1'b1;
                if (bus.i_redirect) fetch_pc_d = target_pc;
                // The abandoned request completes here even if a new redirect
                // arrives, otherwise nothing would ever finish it.
                if (bus.i_instr_valid) state_d = ST_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, fetch PC and abandoned-request address registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    ifu_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (push_entry),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.o_instr_cen  = instr_cen;
    assign bus.o_instr_addr = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
    assign bus.o_if_valid   = !fifo_empty;
    assign bus.o_if_instr   = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign bus.o_if_pc      = fifo_empty ? '0 : fifo_head.pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: randomized memory/decode stimulus against a
// transaction-level model (queue of buffered words plus request bookkeeping).
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam logic [63:0] RPC   = 64'h8000_0000;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_fetch_if bus ();

    ifu_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
    ent_t mq[$];                 // words decode will see, head first
    bit          m_boot;         // still in the post-reset wait cycle
    bit          m_out;          // a memory request is outstanding
    bit          m_junk;         // the outstanding request's data is unwanted
    bit          m_hold;         // waiting for buffer room
    logic [63:0] m_pc_next;      // address of the next word to be kept
    logic [63:0] m_out_addr;     // address of the outstanding request

    logic        e_cen, e_valid;
    logic [63:0] e_addr, e_pc;
    logic [31:0] e_instr;

    int mem_lat = 1;             // response arrives in the mem_lat-th request cycle
    int mem_cnt = 0;
    int ready_mode = 1;          // 0 never ready, 1 always ready, 2 random
    bit late_valid = 0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [63:0] h;
        h = a * 64'h9E37_79B9_7F4A_7C15;
        return h[63:32] ^ a[31:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_boot = 1; m_out = 0; m_junk = 0; m_hold = 0;
        m_pc_next = RPC; m_out_addr = RPC; mem_cnt = 0;
    endtask

    // One cycle at a negedge: expected outputs, drive inputs, advance model
    task automatic step(input bit redir, input logic [63:0] rpc);
        bit resp, pop, rdy;
        ent_t e;
        e_cen   = m_out;
        e_addr  = m_out ? m_out_addr : m_pc_next;
        e_valid = (mq.size() > 0);
        e_instr = e_valid ? mq[0].instr : NOP;
        e_pc    = e_valid ? mq[0].pc : 64'd0;

        rdy = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1);
        bus.i_id_ready = rdy;
        if (late_valid) begin
            bus.i_instr_valid = 1'b1; bus.i_instr = 32'hDEAD_BEEF; late_valid = 0;
        end else if (bus.o_instr_cen) begin
            if (mem_cnt + 1 >= mem_lat) begin
                bus.i_instr_valid = 1'b1; bus.i_instr = mem_word(bus.o_instr_addr); mem_cnt = 0;
            end else begin
                bus.i_instr_valid = 1'b0; bus.i_instr = $urandom; mem_cnt++;
            end
        end else begin
            bus.i_instr_valid = 1'b0; bus.i_instr = $urandom; mem_cnt = 0;
        end
        bus.i_redirect = redir;
        bus.i_redirect_pc = rpc;

        resp = m_out && bus.i_instr_valid;
        pop  = (mq.size() > 0) && rdy && !redir;
        if (redir) begin
            mq.delete();
            m_pc_next = rpc & ~64'h3;
            if (m_boot || m_hold || (m_out && resp)) begin
                m_boot = 0; m_hold = 0; m_out = 1; m_junk = 0; m_out_addr = m_pc_next;
            end else if (m_out) begin
                m_junk = 1;
            end
        end else if (m_boot) begin
            m_boot = 0; m_out = 1; m_out_addr = m_pc_next;
        end else if (m_hold) begin
            if (mq.size() < DEPTH) begin
                m_hold = 0; m_out = 1; m_out_addr = m_pc_next;
            end
            if (pop) void'(mq.pop_front());
        end else begin
            if (pop) void'(mq.pop_front());
            if (resp) begin
                if (m_junk) begin
                    m_junk = 0; m_out_addr = m_pc_next;
                end else begin
                    e.pc = m_out_addr; e.instr = mem_word(m_out_addr);
                    mq.push_back(e);
                    m_pc_next = m_pc_next + 64'd4;
                    if (mq.size() == DEPTH) begin
                        m_out = 0; m_hold = 1;
                    end else begin
                        m_out_addr = m_pc_next;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_instr_valid = 1'b0; bus.i_instr = '0; bus.i_redirect = 1'b0;
        bus.i_redirect_pc = '0; bus.i_id_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        total += 5;
        if (bus.o_instr_cen !== 1'b0) begin bad++; $display("FAIL reset_cen: got %b want 0", bus.o_instr_cen); end
        if (bus.o_instr_addr !== RPC) begin bad++; $display("FAIL reset_addr: got %h want %h", bus.o_instr_addr, RPC); end
        if (bus.o_if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.o_if_valid); end
        if (bus.o_if_instr !== NOP) begin bad++; $display("FAIL reset_instr: got %h want %h", bus.o_if_instr, NOP); end
        if (bus.o_if_pc !== 64'd0) begin bad++; $display("FAIL reset_pc: got %h want 0", bus.o_if_pc); end
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_stream();
        mem_lat = 1; ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            step(0, '0);
            total += 4;
            if (bus.o_instr_cen !== e_cen) begin bad++; $display("FAIL stream_cen: got %b want %b", bus.o_instr_cen, e_cen); end
            if (bus.o_if_valid !== e_valid) begin bad++; $display("FAIL stream_valid: got %b want %b", bus.o_if_valid, e_valid); end
            if (bus.o_if_pc !== e_pc) begin bad++; $display("FAIL stream_pc: got %h want %h", bus.o_if_pc, e_pc); end
            if (bus.o_if_instr !== e_instr) begin bad++; $display("FAIL stream_instr: got %h want %h", bus.o_if_instr, e_instr); end
            $display("stream cyc=%0d valid=%b pc=%h instr=%h", i, bus.o_if_valid, bus.o_if_pc, bus.o_if_instr);
            @(negedge clk);
        end
    endtask

    task automatic test_latency3();
        mem_lat = 3; ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            step(0, '0);
            total += 4;
            if (bus.o_instr_cen !== e_cen) begin bad++; $display("FAIL lat3_cen: got %b want %b", bus.o_instr_cen, e_cen); end
            if (bus.o_instr_addr !== e_addr) begin bad++; $display("FAIL lat3_addr: got %h want %h", bus.o_instr_addr, e_addr); end
            if (bus.o_if_valid !== e_valid) begin bad++; $display("FAIL lat3_valid: got %b want %b", bus.o_if_valid, e_valid); end
            if (bus.o_if_pc !== e_pc) begin bad++; $display("FAIL lat3_pc: got %h want %h", bus.o_if_pc, e_pc); end
            $display("lat3 cyc=%0d cen=%b addr=%h valid=%b pc=%h", i, bus.o_instr_cen, bus.o_instr_addr, bus.o_if_valid, bus.o_if_pc);
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        mem_lat = 1;
        // restart from a known address so the buffered pair is predictable
        step(1, RPC);
        @(negedge clk);
        ready_mode = 0;
        for (int i = 0; i < 24; i++) begin
            if (i == 10) ready_mode = 1;
            step(0, '0);
            total += 5;
            if (bus.o_instr_cen !== e_cen) begin bad++; $display("FAIL bp_cen: got %b want %b", bus.o_instr_cen, e_cen); end
            if (bus.o_instr_addr !== e_addr) begin bad++; $display("FAIL bp_addr: got %h want %h", bus.o_instr_addr, e_addr); end
            if (bus.o_if_valid !== e_valid) begin bad++; $display("FAIL bp_valid: got %b want %b", bus.o_if_valid, e_valid); end
            if (bus.o_if_pc !== e_pc) begin bad++; $display("FAIL bp_pc: got %h want %h", bus.o_if_pc, e_pc); end
            if (bus.o_if_instr !== e_instr) begin bad++; $display("FAIL bp_instr: got %h want %h", bus.o_if_instr, e_instr); end
            if (i == 9) begin
                total += 3;
                if (bus.o_instr_cen !== 1'b0) begin bad++; $display("FAIL bp_stalled_cen: got %b want 0", bus.o_instr_cen); end
                if (bus.o_if_pc !== RPC) begin bad++; $display("FAIL bp_head_pc: got %h want %h", bus.o_if_pc, RPC); end
                if (bus.o_instr_addr !== RPC + 64'd8) begin bad++; $display("FAIL bp_resume_addr: got %h want %h", bus.o_instr_addr, RPC + 64'd8); end
            end
            $display("bp cyc=%0d ready=%b cen=%b valid=%b pc=%h", i, bus.i_id_ready, bus.o_instr_cen, bus.o_if_valid, bus.o_if_pc);
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_drop();
        bit hit;
        mem_lat = 2; ready_mode = 1;
        step(1, RPC);
        @(negedge clk);
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (m_out && !m_junk && m_out_addr == 64'h8000_0010 && mem_cnt == 0) begin
                hit = 1;
            end else begin
                step(0, '0);
                total++;
                if (bus.o_if_pc !== e_pc) begin bad++; $display("FAIL drop_pre_pc: got %h want %h", bus.o_if_pc, e_pc); end
                @(negedge clk);
            end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL drop_setup_timeout: got no request to 80000010 want one"); end
        step(1, 64'h8000_0103);
        $display("drop redirect issued at addr=%h", bus.o_instr_addr);
        @(negedge clk);
        step(0, '0);
        total += 3;
        if (bus.o_instr_cen !== 1'b1) begin bad++; $display("FAIL drop_hold_cen: got %b want 1", bus.o_instr_cen); end
        if (bus.o_instr_addr !== 64'h8000_0010) begin bad++; $display("FAIL drop_hold_addr: got %h want 80000010", bus.o_instr_addr); end
        if (bus.o_if_valid !== 1'b0) begin bad++; $display("FAIL drop_hold_valid: got %b want 0", bus.o_if_valid); end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            step(0, '0);
            if (i == 0) begin
                total += 3;
                if (bus.o_instr_cen !== 1'b1) begin bad++; $display("FAIL drop_next_cen: got %b want 1", bus.o_instr_cen); end
                if (bus.o_instr_addr !== 64'h8000_0100) begin bad++; $display("FAIL drop_next_addr: got %h want 80000100", bus.o_instr_addr); end
                if (bus.o_if_valid !== 1'b0) begin bad++; $display("FAIL drop_next_valid: got %b want 0", bus.o_if_valid); end
            end
            total += 3;
            if (bus.o_instr_addr !== e_addr) begin bad++; $display("FAIL drop_addr: got %h want %h", bus.o_instr_addr, e_addr); end
            if (bus.o_if_valid !== e_valid) begin bad++; $display("FAIL drop_valid: got %b want %b", bus.o_if_valid, e_valid); end
            if (bus.o_if_pc !== e_pc) begin bad++; $display("FAIL drop_pc: got %h want %h", bus.o_if_pc, e_pc); end
            $display("drop cyc=%0d cen=%b addr=%h valid=%b pc=%h", i, bus.o_instr_cen, bus.o_instr_addr, bus.o_if_valid, bus.o_if_pc);
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_same_cycle();
        bit hit;
        mem_lat = 1; ready_mode = 1;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (mq.size() == 1 && m_out && !m_junk) begin
                hit = 1;
            end else begin
                step(0, '0);
                @(negedge clk);
            end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL same_setup_timeout: got no one-entry state want one"); end
        step(1, 64'h8000_0200);
        total++;
        if (bus.o_if_valid !== 1'b1) begin bad++; $display("FAIL same_pre_valid: got %b want 1", bus.o_if_valid); end
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            step(0, '0);
            if (i == 0) begin
                total += 3;
                if (bus.o_if_valid !== 1'b0) begin bad++; $display("FAIL same_flush_valid: got %b want 0", bus.o_if_valid); end
                if (bus.o_instr_cen !== 1'b1) begin bad++; $display("FAIL same_next_cen: got %b want 1", bus.o_instr_cen); end
                if (bus.o_instr_addr !== 64'h8000_0200) begin bad++; $display("FAIL same_next_addr: got %h want 80000200", bus.o_instr_addr); end
            end
            if (i == 1) begin
                total++;
                if (bus.o_if_pc !== 64'h8000_0200) begin bad++; $display("FAIL same_first_pc: got %h want 80000200", bus.o_if_pc); end
            end
            total += 2;
            if (bus.o_if_pc !== e_pc) begin bad++; $display("FAIL same_pc: got %h want %h", bus.o_if_pc, e_pc); end
            if (bus.o_if_instr !== e_instr) begin bad++; $display("FAIL same_instr: got %h want %h", bus.o_if_instr, e_instr); end
            $display("same cyc=%0d valid=%b pc=%h addr=%h", i, bus.o_if_valid, bus.o_if_pc, bus.o_instr_addr);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        mem_lat = 3; ready_mode = 1;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (m_out && mem_cnt == 1) hit = 1;
            else begin step(0, '0); @(negedge clk); end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL rmid_setup_timeout: got no mid-request want one"); end
        #2 rst_n = 1'b0;
        #1;
        total += 5;
        if (bus.o_instr_cen !== 1'b0) begin bad++; $display("FAIL rmid_cen: got %b want 0", bus.o_instr_cen); end
        if (bus.o_instr_addr !== RPC) begin bad++; $display("FAIL rmid_addr: got %h want %h", bus.o_instr_addr, RPC); end
        if (bus.o_if_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", bus.o_if_valid); end
        if (bus.o_if_instr !== NOP) begin bad++; $display("FAIL rmid_instr: got %h want %h", bus.o_if_instr, NOP); end
        if (bus.o_if_pc !== 64'd0) begin bad++; $display("FAIL rmid_pc: got %h want 0", bus.o_if_pc); end
        model_reset();
        @(negedge clk);
        bus.i_instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        late_valid = 1;
        for (int i = 0; i < 8; i++) begin
            step(0, '0);
            if (i == 0) begin
                total++;
                if (bus.o_instr_cen !== 1'b0) begin bad++; $display("FAIL rmid_idle_cen: got %b want 0", bus.o_instr_cen); end
            end
            if (i == 1) begin
                total += 3;
                if (bus.o_instr_cen !== 1'b1) begin bad++; $display("FAIL rmid_first_cen: got %b want 1", bus.o_instr_cen); end
                if (bus.o_instr_addr !== RPC) begin bad++; $display("FAIL rmid_first_addr: got %h want %h", bus.o_instr_addr, RPC); end
                if (bus.o_if_valid !== 1'b0) begin bad++; $display("FAIL rmid_late_ignored: got %b want 0", bus.o_if_valid); end
            end
            total += 3;
            if (bus.o_instr_cen !== e_cen) begin bad++; $display("FAIL rmid_model_cen: got %b want %b", bus.o_instr_cen, e_cen); end
            if (bus.o_instr_addr !== e_addr) begin bad++; $display("FAIL rmid_model_addr: got %h want %h", bus.o_instr_addr, e_addr); end
            if (bus.o_if_pc !== e_pc) begin bad++; $display("FAIL rmid_model_pc: got %h want %h", bus.o_if_pc, e_pc); end
            $display("rmid cyc=%0d cen=%b addr=%h valid=%b", i, bus.o_instr_cen, bus.o_instr_addr, bus.o_if_valid);
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        bit seen_addr0, seen_pc0;
        mem_lat = 1; ready_mode = 1;
        seen_addr0 = 0; seen_pc0 = 0;
        step(1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            step(0, '0);
            if (bus.o_instr_cen && bus.o_instr_addr == 64'd0) seen_addr0 = 1;
            if (bus.o_if_valid && bus.o_if_pc == 64'd0) seen_pc0 = 1;
            total += 2;
            if (bus.o_instr_addr !== e_addr) begin bad++; $display("FAIL wrap_addr: got %h want %h", bus.o_instr_addr, e_addr); end
            if (bus.o_if_pc !== e_pc) begin bad++; $display("FAIL wrap_pc: got %h want %h", bus.o_if_pc, e_pc); end
            $display("wrap cyc=%0d addr=%h pc=%h", i, bus.o_instr_addr, bus.o_if_pc);
            @(negedge clk);
        end
        total += 2;
        if (!seen_addr0) begin bad++; $display("FAIL wrap_fetch0: got no fetch at 0 want one"); end
        if (!seen_pc0) begin bad++; $display("FAIL wrap_head0: got no head pc 0 want one"); end
    endtask

    task automatic test_random();
        bit          r;
        logic [63:0] t;
        ready_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) mem_lat = $urandom_range(1, 4);
            r = ($urandom_range(0, 19) == 0);
            t = {$urandom, $urandom};
            step(r, t);
            total += 5;
            if (bus.o_instr_cen !== e_cen) begin bad++; $display("FAIL rnd_cen: got %b want %b", bus.o_instr_cen, e_cen); end
            if (bus.o_instr_addr !== e_addr) begin bad++; $display("FAIL rnd_addr: got %h want %h", bus.o_instr_addr, e_addr); end
            if (bus.o_if_valid !== e_valid) begin bad++; $display("FAIL rnd_valid: got %b want %b", bus.o_if_valid, e_valid); end
            if (bus.o_if_pc !== e_pc) begin bad++; $display("FAIL rnd_pc: got %h want %h", bus.o_if_pc, e_pc); end
            if (bus.o_if_instr !== e_instr) begin bad++; $display("FAIL rnd_instr: got %h want %h", bus.o_if_instr, e_instr); end
            $display("rnd cyc=%0d redir=%b rdy=%b cen=%b addr=%h valid=%b pc=%h", i, r, bus.i_id_ready, bus.o_instr_cen, bus.o_instr_addr, bus.o_if_valid, bus.o_if_pc);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_latency3();
        test_backpressure();
        test_redirect_drop();
        test_redirect_same_cycle();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch unit at the front of rvcpu.
- Owns the fetch PC and drives the instruction-memory port (o_instr_cen / o_instr_addr / i_instr / i_instr_valid).
- Buffers returned instructions in a small FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes wrong-path instructions.

Parameters:
- RESET_PC, 64'h8000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2).
- NOP_INSTR, 32'h0000_0013, value of o_if_instr when the buffer is empty.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- o_instr_cen  output  1  instruction memory request (held until i_instr_valid)
- o_instr_addr  output  64  instruction fetch address
- i_instr  input  32  instruction returned by memory
- i_instr_valid  input  1  i_instr valid this cycle; completes the outstanding request
- i_redirect  input  1  flush and redirect fetch (branch/jump taken)
- i_redirect_pc  input  64  redirect target; bits [1:0] ignored (forced 0)
- o_if_valid  output  1  buffer head valid to decode
- o_if_instr  output  32  head instruction
- o_if_pc  output  64  PC of head instruction
- i_id_ready  input  1  decode accepts head this cycle

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty.
  - o_instr_cen=0, o_instr_addr=RESET_PC.
  - o_if_valid=0, o_if_instr=NOP_INSTR, o_if_pc=0.
- State machine, states IDLE, REQ, FULL, DROP:
  - IDLE: lasts 1 cycle after rst_n release, then -> REQ.
  - REQ: o_instr_cen=1, o_instr_addr=fetch_pc, both stable until i_instr_valid.
    - On i_instr_valid: push {fetch_pc, i_instr}, fetch_pc+=4.
    - Then -> FULL if FIFO count after this cycle's push/pop equals FIFO_DEPTH, else stay REQ; the next request is issued the following cycle.
  - FULL: o_instr_cen=0. -> REQ in the cycle after count drops below FIFO_DEPTH.
  - DROP: o_instr_cen=1, o_instr_addr=addr of the abandoned request (held).
    - On i_instr_valid: data discarded, no push, -> REQ.
- At most one outstanding memory request. The memory request is never withdrawn before i_instr_valid.
- i_instr_valid outside REQ/DROP is ignored.
- Redirect (i_redirect=1) takes priority over everything else:
  - FIFO flushed next cycle (o_if_valid=0); a same-cycle pop is irrelevant.
  - fetch_pc <= {i_redirect_pc[63:2], 2'b00}.
  - From REQ without i_instr_valid that cycle -> DROP.
  - From REQ with i_instr_valid the same cycle -> response discarded, no push, -> REQ.
  - From IDLE or FULL -> REQ.
  - In DROP -> stay DROP, fetch_pc updated.
- Output side:
  - o_if_valid = FIFO non-empty; o_if_instr/o_if_pc = head entry, NOP_INSTR/0 when empty.
  - Pop when o_if_valid && i_id_ready && !i_redirect.
  - Push and pop in the same cycle are allowed; count unchanged.
- Latency: a response in cycle t is visible on o_if_valid in t+1. First request after reset is at the 2nd rising edge after rst_n release.
- Arithmetic: 64-bit PC increment wraps modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC+4 = 0).
- FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
- Reset mid-request: all state cleared immediately. A late i_instr_valid after reset is ignored in IDLE.

Decomposition:
- Shared package/defines: fetch state encoding (IDLE/REQ/FULL/DROP), RESET_PC, NOP_INSTR, XLEN=64, ILEN=32.
- Sub-module ifu_fifo:
  - Parameterized synchronous FIFO, width 96 ({pc, instr}), depth FIFO_DEPTH.
  - Ports push/pop/flush/full/empty/count.
  - Async active-low reset.
- FSM and PC logic stay in ifu_fetch.

Test Plan:
- Zero-latency memory (i_instr_valid=1 every REQ cycle), i_id_ready=1 -> o_if_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008, ... one per cycle; instrs match the memory model.
- 3-cycle memory latency -> o_instr_addr held stable for 3 cycles with cen=1; o_if_valid pulses once every 3 cycles with consecutive PCs.
- i_id_ready=0 with zero-latency memory -> exactly 2 entries (0x8000_0000, 0x8000_0004) buffered, state FULL, cen=0. Raise ready -> pops in order, fetch resumes at 0x8000_0008.
- Redirect to 0x8000_0103 while a request to 0x8000_0010 is outstanding (latency 2) -> cen held at 0x8000_0010 until valid, that data dropped; next request at 0x8000_0100; o_if_valid=0 meanwhile.
- Redirect and i_instr_valid in the same cycle, FIFO holding 1 entry -> FIFO empty next cycle, no push; next request at the redirect target.
- Assert rst_n=0 mid-request, then release -> outputs at reset values immediately; first new request at 0x8000_0000 after the IDLE cycle. Separately, redirect to 0xFFFF_FFFF_FFFF_FFFC -> the next fetch address wraps to 0.
